// File: rtl/gb80_pkg.sv
// Shared opcodes, register codes, pair indices and sequencer states.
// States RD2/WR2 exist only when GB80_PAIR_OPS_EN is defined.
package gb80_pkg;

    typedef enum logic [1:0] {
        OpMove    = 2'd0,
        OpLoadi8  = 2'd1,
        OpLoadi16 = 2'd2,
        OpRead16  = 2'd3
    } op_e;

    localparam logic [2:0] RegB   = 3'd0;
    localparam logic [2:0] RegC   = 3'd1;
    localparam logic [2:0] RegD   = 3'd2;
    localparam logic [2:0] RegE   = 3'd3;
    localparam logic [2:0] RegH   = 3'd4;
    localparam logic [2:0] RegL   = 3'd5;
    localparam logic [2:0] RegMem = 3'd6;
    localparam logic [2:0] RegA   = 3'd7;

    localparam logic [1:0] PairBc = 2'd0;
    localparam logic [1:0] PairDe = 2'd1;
    localparam logic [1:0] PairHl = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
`ifdef GB80_PAIR_OPS_EN
        StRd2,
`endif
        StLat,
        StWr,
`ifdef GB80_PAIR_OPS_EN
        StWr2,
`endif
        StRsp
    } state_e;

endpackage

// File: rtl/reg_pair_decode.sv
// Translates a register-pair index into its {hi,lo} register codes.
// Indices outside BC/DE/HL raise o_illegal with zero codes.
module reg_pair_decode
    import gb80_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic [ADDRESS_WIDTH-1:0] i_pair,
    output logic [ADDRESS_WIDTH-1:0] o_hi,
    output logic [ADDRESS_WIDTH-1:0] o_lo,
    output logic                     o_illegal
);

    always_comb begin
        o_hi      = '0;
        o_lo      = '0;
        o_illegal = 1'b0;
        case (i_pair)
            ADDRESS_WIDTH'(PairBc): begin
                o_hi = ADDRESS_WIDTH'(RegB);
                o_lo = ADDRESS_WIDTH'(RegC);
            end
            ADDRESS_WIDTH'(PairDe): begin
                o_hi = ADDRESS_WIDTH'(RegD);
                o_lo = ADDRESS_WIDTH'(RegE);
            end
            ADDRESS_WIDTH'(PairHl): begin
                o_hi = ADDRESS_WIDTH'(RegH);
                o_lo = ADDRESS_WIDTH'(RegL);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/register_sequencer.sv
// Turns MOVE/LOADI8/LOADI16/READ16 commands into register-file strobes and one response.
// Pair ops (LOADI16/READ16) are enabled by GB80_PAIR_OPS_EN, otherwise rejected as errors.
module register_sequencer
    import gb80_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [1:0]                i_cmd_op,
    input  logic [ADDRESS_WIDTH-1:0]  i_cmd_dst,
    input  logic [ADDRESS_WIDTH-1:0]  i_cmd_src,
    input  logic [2*DATA_WIDTH-1:0]   i_cmd_imm,
    output logic                      o_rf_wr_en,
    output logic                      o_rf_rd_en,
    output logic [ADDRESS_WIDTH-1:0]  o_rf_addr,
    output logic [DATA_WIDTH-1:0]     o_rf_data,
    input  logic [DATA_WIDTH-1:0]     i_rf_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [2*DATA_WIDTH-1:0]   o_rsp_data,
    output logic                      o_rsp_err
);

    localparam logic [ADDRESS_WIDTH-1:0] MemCode = ADDRESS_WIDTH'(RegMem);

    state_e                    r_state;
    op_e                       r_op;
    logic [ADDRESS_WIDTH-1:0]  r_dst;
    logic                      r_cmd_ready;
    logic                      r_wr_en;
    logic                      r_rd_en;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_rsp_valid;
    logic [2*DATA_WIDTH-1:0]   r_rsp_data;
    logic                      r_rsp_err;
    logic                      w_illegal;

`ifdef GB80_PAIR_OPS_EN
    logic [ADDRESS_WIDTH-1:0]  w_hi;
    logic [ADDRESS_WIDTH-1:0]  w_lo;
    logic                      w_pair_illegal;
    logic [ADDRESS_WIDTH-1:0]  r_lo;
    logic [DATA_WIDTH-1:0]     r_imm_lo;
    logic [DATA_WIDTH-1:0]     r_byte_hi;

    reg_pair_decode #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_pair_decode (
        .i_pair    (i_cmd_dst),
        .o_hi      (w_hi),
        .o_lo      (w_lo),
        .o_illegal (w_pair_illegal)
    );
`else
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^i_cmd_imm[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

    always_comb begin
        w_illegal = 1'b0;
        case (op_e'(i_cmd_op))
            OpMove:   w_illegal = (i_cmd_dst == MemCode) || (i_cmd_src == MemCode);
            OpLoadi8: w_illegal = (i_cmd_dst == MemCode);
`ifdef GB80_PAIR_OPS_EN
            default:  w_illegal = w_pair_illegal;
`else
            default:  w_illegal = 1'b1;
`endif
        endcase
    end

    // Strobes default low each cycle, so addr/data return to zero whenever no strobe is driven.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_op        <= OpMove;
            r_dst       <= '0;
            r_cmd_ready <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifdef GB80_PAIR_OPS_EN
            r_lo        <= '0;
            r_imm_lo    <= '0;
            r_byte_hi   <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            case (r_state)
                StIdle: begin
                    if (r_cmd_ready && i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= op_e'(i_cmd_op);
                        r_dst       <= i_cmd_dst;
`ifdef GB80_PAIR_OPS_EN
                        r_lo        <= w_lo;
                        r_imm_lo    <= i_cmd_imm[DATA_WIDTH-1:0];
`endif
                        if (w_illegal) begin
                            r_state     <= StRsp;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            case (op_e'(i_cmd_op))
                                OpMove: begin
                                    r_state <= StRd;
                                    r_rd_en <= 1'b1;
                                    r_addr  <= i_cmd_src;
                                end
                                OpLoadi8: begin
                                    r_state <= StWr;
                                    r_wr_en <= 1'b1;
                                    r_addr  <= i_cmd_dst;
                                    r_wdata <= i_cmd_imm[DATA_WIDTH-1:0];
                                end
`ifdef GB80_PAIR_OPS_EN
                                OpLoadi16: begin
                                    r_state <= StWr;
                                    r_wr_en <= 1'b1;
                                    r_addr  <= w_hi;
                                    r_wdata <= i_cmd_imm[2*DATA_WIDTH-1:DATA_WIDTH];
                                end
                                OpRead16: begin
                                    r_state <= StRd;
                                    r_rd_en <= 1'b1;
                                    r_addr  <= w_hi;
                                end
`endif
                                default: r_state <= StIdle;
                            endcase
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                StRd: begin
`ifdef GB80_PAIR_OPS_EN
                    if (r_op == OpRead16) begin
                        r_state <= StRd2;
                        r_rd_en <= 1'b1;
                        r_addr  <= r_lo;
                    end else
`endif
                    r_state <= StLat;
                end
`ifdef GB80_PAIR_OPS_EN
                StRd2: begin
                    r_byte_hi <= i_rf_data;
                    r_state   <= StLat;
                end
`endif
                StLat: begin
                    if (r_op == OpMove) begin
                        r_state <= StWr;
                        r_wr_en <= 1'b1;
                        r_addr  <= r_dst;
                        r_wdata <= i_rf_data;
                    end else begin
                        r_state     <= StRsp;
                        r_rsp_valid <= 1'b1;
`ifdef GB80_PAIR_OPS_EN
                        r_rsp_data  <= {r_byte_hi, i_rf_data};
`else
                        r_rsp_data  <= {{DATA_WIDTH{1'b0}}, i_rf_data};
`endif
                    end
                end
                StWr: begin
`ifdef GB80_PAIR_OPS_EN
                    if (r_op == OpLoadi16) begin
                        r_state   <= StWr2;
                        r_wr_en   <= 1'b1;
                        r_addr    <= r_lo;
                        r_wdata   <= r_imm_lo;
                        r_byte_hi <= r_wdata;
                    end else
`endif
                    begin
                        r_state     <= StRsp;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= {{DATA_WIDTH{1'b0}}, r_wdata};
                    end
                end
`ifdef GB80_PAIR_OPS_EN
                StWr2: begin
                    r_state     <= StRsp;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= {r_byte_hi, r_wdata};
                end
`endif
                StRsp: begin
                    if (i_rsp_ready) begin
                        r_state     <= StIdle;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= '0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rf_wr_en  = r_wr_en;
    assign o_rf_rd_en  = r_rd_en;
    assign o_rf_addr   = r_addr;
    assign o_rf_data   = r_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_register_sequencer.sv
// Directed bench for register_sequencer with a registered-read register-file model.
// Pair-op expectations follow GB80_PAIR_OPS_EN.
module tb_register_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [2:0]  cmd_dst = '0;
    logic [2:0]  cmd_src = '0;
    logic [15:0] cmd_imm = '0;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [2:0]  rf_addr;
    logic [7:0]  rf_wdata;
    logic [7:0]  rf_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rf [8] = '{default: 8'h00};
    logic [2:0] wr_addr_log [64];
    logic [7:0] wr_data_log [64];
    logic [2:0] rd_addr_log [64];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int idle_nz = 0;

    register_sequencer #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (3)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_dst   (cmd_dst),
        .i_cmd_src   (cmd_src),
        .i_cmd_imm   (cmd_imm),
        .o_rf_wr_en  (rf_wr_en),
        .o_rf_rd_en  (rf_rd_en),
        .o_rf_addr   (rf_addr),
        .o_rf_data   (rf_wdata),
        .i_rf_data   (rf_rdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Read data is valid only the cycle after rd_en; otherwise it is noise.
    always @(posedge clk) begin
        rf_rdata <= rf_rd_en ? rf[rf_addr] : 8'($urandom);
        if (rf_wr_en) begin
            rf[rf_addr] <= rf_wdata;
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] <= rf_addr;
                wr_data_log[wr_cnt] <= rf_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (rf_rd_en) begin
            if (rd_cnt < 64) rd_addr_log[rd_cnt] <= rf_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (rf_wr_en && rf_rd_en) both_cnt <= both_cnt + 1;
        if (!rf_wr_en && !rf_rd_en && (rf_addr != 3'd0 || rf_wdata != 8'd0))
            idle_nz <= idle_nz + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is seen (or a bound expires).
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic [15:0] imm, output int acc_wait, output int lat);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        cmd_imm   = imm;
        acc_wait  = 0;
        while (!cmd_ready && acc_wait < 20) begin
            @(negedge clk);
            acc_wait++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_dst   = 3'($urandom);
        cmd_src   = 3'($urandom);
        cmd_imm   = 16'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq(tag, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int wr0, rd0, aw, lat;
        logic pair_en;
`ifdef GB80_PAIR_OPS_EN
        pair_en = 1'b1;
`else
        pair_en = 1'b0;
`endif
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int wr0, rd0, aw, lat;
        logic pair_en;
`ifdef GB80_PAIR_OPS_EN
        pair_en = 1'b1;
`else
        pair_en = 1'b0;
`endif
        // Reset holds every output at zero
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {cmd_ready, rf_wr_en, rf_rd_en, rsp_valid, rsp_err, rf_addr, rf_wdata, rsp_data},
                 32'd0);
        reset = 1'b0;
        check_eq("ready_at_release", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check_eq("ready_after_release", {31'd0, cmd_ready}, 32'd1);

        // LOADI8 B=0x5A
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_cmd(2'd1, 3'd0, 3'd0, 16'h005A, aw, lat);
        check_eq("loadi8_lat", lat, 2);
        check_eq("loadi8_rsp", {15'd0, rsp_err, rsp_data}, 32'h0000_005A);
        check_eq("loadi8_nwr", wr_cnt - wr0, 1);
        check_eq("loadi8_nrd", rd_cnt - rd0, 0);
        check_eq("loadi8_wr", {21'd0, wr_addr_log[wr0], wr_data_log[wr0]}, {21'd0, 3'd0, 8'h5A});
        finish_rsp("loadi8_idle");

        // MOVE A <- B
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_cmd(2'd0, 3'd7, 3'd0, 16'hFFFF, aw, lat);
        check_eq("move_lat", lat, 4);
        check_eq("move_rsp", {15'd0, rsp_err, rsp_data}, 32'h0000_005A);
        check_eq("move_nrd", rd_cnt - rd0, 1);
        check_eq("move_rd_addr", {29'd0, rd_addr_log[rd0]}, 32'd0);
        check_eq("move_nwr", wr_cnt - wr0, 1);
        check_eq("move_wr", {21'd0, wr_addr_log[wr0], wr_data_log[wr0]}, {21'd0, 3'd7, 8'h5A});
        finish_rsp("move_idle");

        // LOADI16 HL=0xC0DE
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_cmd(2'd2, 3'd2, 3'd0, 16'hC0DE, aw, lat);
        if (pair_en) begin
            check_eq("loadi16_lat", lat, 3);
            check_eq("loadi16_rsp", {15'd0, rsp_err, rsp_data}, 32'h0000_C0DE);
            check_eq("loadi16_nwr", wr_cnt - wr0, 2);
            check_eq("loadi16_wr_h", {21'd0, wr_addr_log[wr0], wr_data_log[wr0]},
                     {21'd0, 3'd4, 8'hC0});
            check_eq("loadi16_wr_l", {21'd0, wr_addr_log[wr0+1], wr_data_log[wr0+1]},
                     {21'd0, 3'd5, 8'hDE});
        end else begin
            check_eq("loadi16_off_lat", lat, 1);
            check_eq("loadi16_off_rsp", {15'd0, rsp_err, rsp_data}, 32'h0001_0000);
            check_eq("loadi16_off_nwr", wr_cnt - wr0, 0);
        end
        finish_rsp("loadi16_idle");

        // READ16 HL
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_cmd(2'd3, 3'd2, 3'd0, 16'h0000, aw, lat);
        if (pair_en) begin
            check_eq("read16_lat", lat, 4);
            check_eq("read16_rsp", {15'd0, rsp_err, rsp_data}, 32'h0000_C0DE);
            check_eq("read16_nrd", rd_cnt - rd0, 2);
            check_eq("read16_rd_addr", {26'd0, rd_addr_log[rd0], rd_addr_log[rd0+1]},
                     {26'd0, 3'd4, 3'd5});
        end else begin
            check_eq("read16_off_lat", lat, 1);
            check_eq("read16_off_rsp", {15'd0, rsp_err, rsp_data}, 32'h0001_0000);
            check_eq("read16_off_nrd", rd_cnt - rd0, 0);
        end
        finish_rsp("read16_idle");

        // MOVE to MEMORY is rejected
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_cmd(2'd0, 3'd6, 3'd0, 16'h0000, aw, lat);
        check_eq("move_mem_lat", lat, 1);
        check_eq("move_mem_rsp", {15'd0, rsp_err, rsp_data}, 32'h0001_0000);
        check_eq("move_mem_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
        finish_rsp("move_mem_idle");

        // READ16 with illegal pair 3
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_cmd(2'd3, 3'd3, 3'd0, 16'h0000, aw, lat);
        check_eq("read16_p3_lat", lat, 1);
        check_eq("read16_p3_rsp", {15'd0, rsp_err, rsp_data}, 32'h0001_0000);
        check_eq("read16_p3_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
        finish_rsp("read16_p3_idle");

        // Response back-pressure: LOADI8 C=0x33 held for 5 cycles
        do_cmd(2'd1, 3'd1, 3'd0, 16'h0033, aw, lat);
        check_eq("hold_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("hold_cycle%0d", i),
                     {13'd0, rsp_valid, rsp_err, cmd_ready, rsp_data}, {13'd0, 3'b100, 16'h0033});
        end
        finish_rsp("hold_idle");
        wr0 = wr_cnt;
        do_cmd(2'd1, 3'd2, 3'd0, 16'h0044, aw, lat);
        check_eq("b2b_accept_wait", aw, 0);
        check_eq("b2b_lat", lat, 2);
        check_eq("b2b_wr", {21'd0, wr_addr_log[wr0], wr_data_log[wr0]}, {21'd0, 3'd2, 8'h44});
        finish_rsp("b2b_idle");

        // Reset during the second write of LOADI16 BC (or during the LOADI8 write)
        wr0 = wr_cnt;
        cmd_valid = 1'b1;
        cmd_op    = pair_en ? 2'd2 : 2'd1;
        cmd_dst   = pair_en ? 3'd0 : 3'd1;
        cmd_imm   = pair_en ? 16'h1234 : 16'h0077;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (pair_en) @(negedge clk);
        check_eq("abort_strobe", {28'd0, rf_wr_en, rf_addr}, {28'd0, 1'b1, 3'd1});
        reset = 1'b1;
        #1;
        check_eq("abort_outputs",
                 {cmd_ready, rf_wr_en, rf_rd_en, rsp_valid, rsp_err, rf_addr, rf_wdata, rsp_data},
                 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_nwr", wr_cnt - wr0, pair_en ? 1 : 0);
        check_eq("abort_c_kept", {24'd0, rf[1]}, 32'h33);
        check_eq("abort_b", {24'd0, rf[0]}, pair_en ? 32'h12 : 32'h5A);
        check_eq("abort_ready", {30'd0, cmd_ready, rsp_valid}, 32'b10);

        // Recovery after the abort
        do_cmd(2'd1, 3'd3, 3'd0, 16'h00A5, aw, lat);
        check_eq("recover_lat", lat, 2);
        check_eq("recover_rsp", {15'd0, rsp_err, rsp_data}, 32'h0000_00A5);
        finish_rsp("recover_idle");

        check_eq("never_both_strobes", both_cnt, 0);
        check_eq("idle_addr_data_zero", idle_nz, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_sequencer.md
REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, register byte width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 3, register code width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset. Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous reset, active-high.
REQ-004 SHALL have the following command, response and register-file master ports:
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid&ready.
- i_cmd_op  in  2  opcode: 0 MOVE, 1 LOADI8, 2 LOADI16, 3 READ16.
- i_cmd_dst  in  ADDRESS_WIDTH  destination register code, or pair index for ops 2/3.
- i_cmd_src  in  ADDRESS_WIDTH  source register code (MOVE only).
- i_cmd_imm  in  2*DATA_WIDTH  immediate data.
- o_rf_wr_en  out  1  register-file write strobe.
- o_rf_rd_en  out  1  register-file read strobe.
- o_rf_addr  out  ADDRESS_WIDTH  register-file address.
- o_rf_data  out  DATA_WIDTH  register-file write data.
- i_rf_data  in  DATA_WIDTH  register-file read data (registered, valid the cycle after the rd_en cycle).
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed when valid&ready.
- o_rsp_data  out  2*DATA_WIDTH  response data.
- o_rsp_err  out  1  command rejected; qualified by o_rsp_valid.

Function
REQ-005 SHALL use register codes 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 MEMORY, 7 A.
REQ-006 SHALL map pair indices to {hi,lo} codes as 0 BC {0,1}, 1 DE {2,3}, 2 HL {4,5}; pair index 3 or higher is illegal.
REQ-007 SHALL implement states IDLE, RD, RD2, LAT, WR, WR2, RSP; o_cmd_ready=1 only in IDLE; all command fields are captured on acceptance.
REQ-008 SHALL sequence MOVE as IDLE->RD (rd_en, addr=src)->LAT (capture i_rf_data)->WR (wr_en, addr=dst, data=captured)->RSP; rsp_data={0,byte}.
REQ-009 SHALL sequence LOADI8 as IDLE->WR (addr=dst, data=imm[7:0])->RSP; rsp_data={0,imm[7:0]}.
REQ-010 SHALL sequence LOADI16 as IDLE->WR (hi code, imm[15:8])->WR2 (lo code, imm[7:0])->RSP; rsp_data=imm.
REQ-011 SHALL sequence READ16 as IDLE->RD (hi)->RD2 (lo, capture hi)->LAT (capture lo)->RSP; rsp_data={hi,lo}.
REQ-012 SHALL reject any code 6 used as dst or src of MOVE/LOADI8, and any illegal pair index, going IDLE->RSP with o_rsp_err=1, rsp_data=0, and no rf strobe.
REQ-013 SHALL never assert o_rf_wr_en and o_rf_rd_en in the same cycle, and SHALL drive o_rf_addr and o_rf_data to 0 when no strobe is active.
REQ-014 SHALL hold o_rsp_valid, o_rsp_data and o_rsp_err stable in RSP until i_rsp_ready; on handshake it SHALL return to IDLE, and the next command can be accepted one cycle later.
REQ-015 SHALL ignore i_cmd_* and i_rf_data outside the documented capture cycles.
REQ-016 SHALL give a MOVE acceptance-to-rsp_valid latency of 4 cycles, LOADI8 2, LOADI16 3, READ16 4, and an error response 1.

Reset
REQ-017 SHALL make i_reset force state IDLE immediately and drive all outputs to 0 (o_cmd_ready=0) while asserted; o_cmd_ready SHALL rise the first cycle after deassertion.
REQ-018 SHALL make reset mid-operation abort the command with no further strobes and discard any pending response.

Configuration
REQ-019 SHALL support macro GB80_PAIR_OPS_EN; when it is defined, LOADI16 and READ16 behave per REQ-010/011.
REQ-020 SHALL, when GB80_PAIR_OPS_EN is undefined, reject ops 2/3 per REQ-012, omit states RD2/WR2, and leave ports unchanged.

Structure
REQ-021 SHALL place opcode constants, register codes, pair indices and the state enum in shared package gb80_pkg.
REQ-022 SHALL place pair-index to {hi,lo} code translation plus the illegal flag in sub-module reg_pair_decode.

Verification
REQ-023 SHALL cover: LOADI8 dst=0 imm=0x005A -> one wr_en, addr 0, data 0x5A; rsp_data 0x005A after 2 cycles, err=0.
REQ-024 SHALL cover: after B=0x5A, MOVE src=0 dst=7 -> rd_en addr 0, then wr_en addr 7 data 0x5A; rsp_data 0x005A after 4 cycles.
REQ-025 SHALL cover: LOADI16 pair 2 imm=0xC0DE then READ16 pair 2 -> writes H=0xC0, L=0xDE; read rsp_data 0xC0DE.
REQ-026 SHALL cover: MOVE dst=6, and separately READ16 pair 3 -> rsp_err=1, rsp_data 0, no rf strobes.
REQ-027 SHALL cover: i_rsp_ready held low 5 cycles -> rsp held stable, o_cmd_ready=0; the next command is accepted 1 cycle after the handshake.
REQ-028 SHALL cover: i_reset asserted during WR2 of LOADI16 BC -> no L/C write, all outputs 0, IDLE after release.
